// File: rtl/render_frame_scheduler.sv
// Frame sequencer for the full_renderer pipeline.
// Walks the viewport one pixel per handshake, limits outstanding pixels with a
// credit counter, and turns returned pixel coordinates into frame-buffer writes.
module render_frame_scheduler #(
    parameter int START_X       = 390,
    parameter int START_Y       = 390,
    parameter int END_X         = 634,
    parameter int END_Y         = 765,
    parameter int REGION_DIVIDE = 530,
    parameter int MAX_INFLIGHT  = 512,
    parameter int ADDR_W        = 17
) (
    input  logic              aclk,
    input  logic              rst_in,
    input  logic              frame_start,
    output logic [10:0]       hcount_axis_tdata,
    output logic [9:0]        vcount_axis_tdata,
    output logic              hcount_axis_tvalid,
    input  logic              hcount_axis_tready,
    output logic [1:0]        select_objs,
    input  logic              pixel_valid,
    input  logic [10:0]       pixel_hcount,
    input  logic [9:0]        pixel_vcount,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_en,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        frames_dropped,
    output logic              err_underflow,
    output logic              err_range
);

    localparam int CNT_W  = $clog2(MAX_INFLIGHT + 1);
    localparam int VIEW_W = END_X - START_X;

    localparam logic [10:0]      FIRST_X = 11'(START_X);
    localparam logic [10:0]      LAST_X  = 11'(END_X - 1);
    localparam logic [10:0]      BOUND_X = 11'(END_X);
    localparam logic [9:0]       FIRST_Y = 10'(START_Y);
    localparam logic [9:0]       LAST_Y  = 10'(END_Y - 1);
    localparam logic [9:0]       BOUND_Y = 10'(END_Y);
    localparam logic [9:0]       DIV_Y   = 10'(REGION_DIVIDE);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [10:0]      h_ptr;
    logic [9:0]       v_ptr;
    logic [CNT_W-1:0] inflight;
    logic             handshake;
    logic             last_pixel;
    logic             in_range;
    logic             wr_en_p1;
    logic [ADDR_W-1:0] wr_addr_p1;

    // Linear frame-buffer offset of a viewport pixel; computed wide, then truncated.
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [10:0] h, input logic [9:0] v);
        logic signed [31:0] dx;
        logic signed [31:0] dy;
        logic signed [31:0] lin;
        dx  = signed'(32'(h)) - START_X;
        dy  = signed'(32'(v)) - START_Y;
        lin = dx + dy * VIEW_W;
        return lin[ADDR_W-1:0];
    endfunction

    // Issue-side signals; pointer outputs read as zero outside ISSUE.
    assign hcount_axis_tvalid = (state == ISSUE) && (inflight < MAX_CNT);
    assign handshake          = hcount_axis_tvalid && hcount_axis_tready;
    assign last_pixel         = (h_ptr == LAST_X) && (v_ptr == LAST_Y);
    assign hcount_axis_tdata  = (state == ISSUE) ? h_ptr : 11'd0;
    assign vcount_axis_tdata  = (state == ISSUE) ? v_ptr : 10'd0;
    assign select_objs        = (state != ISSUE) ? 2'b00 :
                                (v_ptr < DIV_Y)   ? 2'b11 : 2'b10;
    assign busy               = (state == ISSUE) || (state == DRAIN);
    assign frame_done         = (state == DONE);
    assign wr_en              = wr_en_p1;
    assign wr_addr            = wr_addr_p1;

    assign in_range = (pixel_hcount >= FIRST_X) && (pixel_hcount < BOUND_X) &&
                      (pixel_vcount >= FIRST_Y) && (pixel_vcount < BOUND_Y);

    // State register.
    always_ff @(posedge aclk) begin
        if (rst_in) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; DRAIN exits only once the last return has been
    // consumed, which is also the edge that registers its write.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (frame_start) state_next = ISSUE;
            ISSUE:   if (handshake && last_pixel) state_next = DRAIN;
            DRAIN:   if ((inflight == '0) && !pixel_valid) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Raster pointer: restarts on frame start, advances on every handshake.
    always_ff @(posedge aclk) begin
        if (rst_in) begin
            h_ptr <= FIRST_X;
            v_ptr <= FIRST_Y;
        end else if ((state == IDLE) && frame_start) begin
            h_ptr <= FIRST_X;
            v_ptr <= FIRST_Y;
        end else if (handshake) begin
            if (h_ptr == LAST_X) begin
                h_ptr <= FIRST_X;
                v_ptr <= v_ptr + 10'd1;
            end else begin
                h_ptr <= h_ptr + 11'd1;
            end
        end
    end

    // Credit counter; a return with nothing outstanding is flagged, not counted.
    always_ff @(posedge aclk) begin
        if (rst_in) begin
            inflight      <= '0;
            err_underflow <= 1'b0;
        end else begin
            case ({handshake, pixel_valid})
                2'b10: inflight <= inflight + 1'b1;
                2'b01: begin
                    if (inflight == '0) err_underflow <= 1'b1;
                    else                inflight      <= inflight - 1'b1;
                end
                default: inflight <= inflight;
            endcase
        end
    end

    // Write stage p1: one registered cycle from returned pixel to write strobe.
    always_ff @(posedge aclk) begin
        if (rst_in) begin
            wr_en_p1   <= 1'b0;
            wr_addr_p1 <= '0;
            err_range  <= 1'b0;
        end else begin
            wr_en_p1 <= pixel_valid && in_range;
            if (pixel_valid && in_range)  wr_addr_p1 <= pixel_addr(pixel_hcount, pixel_vcount);
            if (pixel_valid && !in_range) err_range  <= 1'b1;
        end
    end

    // Count frame requests that arrive while a frame is still in progress.
    always_ff @(posedge aclk) begin
        if (rst_in)
            frames_dropped <= 8'd0;
        else if (frame_start && (state != IDLE) && (frames_dropped != 8'hFF))
            frames_dropped <= frames_dropped + 8'd1;
    end

endmodule

// File: tb/tb_render_frame_scheduler.sv
// Bench for render_frame_scheduler on a reduced viewport with a queue-based
// renderer model and a transaction-level scoreboard.
module tb_render_frame_scheduler;

    localparam int SX = 390, SY = 390, EX = 400, EY = 402, DIV = 396;
    localparam int MAXI = 8, AW = 17;
    localparam int W = EX - SX, H = EY - SY, TOTAL = W * H;
    localparam int BIG = 32'h7fffffff;

    logic          aclk = 1'b0;
    logic          rst_in = 1'b1;
    logic          frame_start = 1'b0;
    logic [10:0]   hcount_axis_tdata;
    logic [9:0]    vcount_axis_tdata;
    logic          hcount_axis_tvalid;
    logic          hcount_axis_tready = 1'b0;
    logic [1:0]    select_objs;
    logic          pixel_valid = 1'b0;
    logic [10:0]   pixel_hcount = '0;
    logic [9:0]    pixel_vcount = '0;
    logic [AW-1:0] wr_addr;
    logic          wr_en;
    logic          busy;
    logic          frame_done;
    logic [7:0]    frames_dropped;
    logic          err_underflow;
    logic          err_range;

    render_frame_scheduler #(
        .START_X(SX), .START_Y(SY), .END_X(EX), .END_Y(EY),
        .REGION_DIVIDE(DIV), .MAX_INFLIGHT(MAXI), .ADDR_W(AW)
    ) dut (
        .aclk(aclk), .rst_in(rst_in), .frame_start(frame_start),
        .hcount_axis_tdata(hcount_axis_tdata), .vcount_axis_tdata(vcount_axis_tdata),
        .hcount_axis_tvalid(hcount_axis_tvalid), .hcount_axis_tready(hcount_axis_tready),
        .select_objs(select_objs), .pixel_valid(pixel_valid),
        .pixel_hcount(pixel_hcount), .pixel_vcount(pixel_vcount),
        .wr_addr(wr_addr), .wr_en(wr_en), .busy(busy), .frame_done(frame_done),
        .frames_dropped(frames_dropped), .err_underflow(err_underflow), .err_range(err_range)
    );

    always #5 aclk = ~aclk;

    int checks = 0, failures = 0;

    // Scoreboard state
    int  cycle = 0;
    bit  frame_active = 0;
    int  issued = 0, returned = 0, outst = 0, done_cyc = BIG;
    int  dropped_m = 0;
    bit  uf_m = 0, rg_m = 0;
    logic [AW-1:0] addr_m = '0;
    int  q_h[$], q_v[$], q_due[$];

    // Stimulus controls
    int  lat = 3, pct = 100;
    bit  fs_next = 0, rst_next = 1;
    bit  inj_valid = 0;
    int  inj_h = 0, inj_v = 0;

    // Observations
    int  wr_cnt = 0, last_wr_addr = -1, last_wr_cyc = -1;
    int  done_seen = 0, done_seen_cyc = -1;
    int  first_h = -1, first_v = -1, last_h = -1, last_v = -1;
    int  prev_hs_h = -1, wraps = 0, sel11_cnt = 0;
    int  max_outst = 0, stall_cnt = 0;

    // One clock of stimulus plus scoreboard comparison.
    task automatic step();
        bit hs, exp_tv, pv_s, fs_s, rst_s, pre_active, uf_now, inr, exp_wr;
        int ph, pvv, eh, ev;
        logic [1:0] esel;
        logic [31:0] a;
        @(negedge aclk);
        eh = SX + issued % W;
        ev = SY + issued / W;
        esel = (ev < DIV) ? 2'b11 : 2'b10;
        exp_tv = frame_active && (issued < TOTAL) && (outst < MAXI);
        checks++;
        if (hcount_axis_tvalid !== exp_tv) begin
            failures++;
            $display("FAIL tvalid cyc=%0d got=%b exp=%b", cycle, hcount_axis_tvalid, exp_tv);
        end
        if (exp_tv) begin
            checks++;
            if (hcount_axis_tdata !== 11'(eh) || vcount_axis_tdata !== 10'(ev) || select_objs !== esel) begin
                failures++;
                $display("FAIL issue_data cyc=%0d got=(%0d,%0d,%b) exp=(%0d,%0d,%b)", cycle,
                         hcount_axis_tdata, vcount_axis_tdata, select_objs, eh, ev, esel);
            end
        end
        if (frame_active && issued < TOTAL && !hcount_axis_tvalid) stall_cnt++;
        hs = hcount_axis_tvalid && hcount_axis_tready;
        if (hs) begin
            if (first_h < 0) begin first_h = hcount_axis_tdata; first_v = vcount_axis_tdata; end
            last_h = hcount_axis_tdata; last_v = vcount_axis_tdata;
            if (prev_hs_h == EX - 1 && hcount_axis_tdata == 11'(SX)) wraps++;
            prev_hs_h = hcount_axis_tdata;
            if (select_objs == 2'b11) sel11_cnt++;
        end
        pv_s  = pixel_valid;
        ph    = pixel_hcount;
        pvv   = pixel_vcount;
        fs_s  = frame_start;
        rst_s = rst_in;

        @(posedge aclk);
        #1;
        cycle++;
        if (rst_s) begin
            frame_active = 0; outst = 0; uf_m = 0; rg_m = 0; dropped_m = 0;
            addr_m = '0; done_cyc = BIG; exp_wr = 0;
            q_h.delete(); q_v.delete(); q_due.delete();
        end else begin
            pre_active = frame_active;
            uf_now = pv_s && !hs && outst == 0;
            if (uf_now) uf_m = 1;
            else if (hs && !pv_s) outst++;
            else if (pv_s && !hs) outst--;
            if (outst > max_outst) max_outst = outst;
            if (hs) begin
                q_h.push_back(eh); q_v.push_back(ev); q_due.push_back(cycle + lat);
                issued++;
            end
            if (pv_s && !uf_now) returned++;
            if (pre_active && pv_s && returned == TOTAL && issued == TOTAL && done_cyc == BIG)
                done_cyc = cycle + 1;
            inr = ph >= SX && ph < EX && pvv >= SY && pvv < EY;
            exp_wr = pv_s && inr;
            if (exp_wr) begin
                a = 32'((ph - SX) + (pvv - SY) * W);
                addr_m = a[AW-1:0];
            end
            if (pv_s && !inr) rg_m = 1;
            if (fs_s) begin
                if (!pre_active) begin
                    frame_active = 1; issued = 0; returned = 0; done_cyc = BIG;
                end else if (dropped_m < 255) dropped_m++;
            end
            if (pre_active && cycle == done_cyc + 1) frame_active = 0;
        end
        checks++;
        if (wr_en !== exp_wr) begin
            failures++;
            $display("FAIL wr_en cyc=%0d got=%b exp=%b", cycle, wr_en, exp_wr);
        end
        checks++;
        if (wr_addr !== addr_m) begin
            failures++;
            $display("FAIL wr_addr cyc=%0d got=%0d exp=%0d", cycle, wr_addr, addr_m);
        end
        checks++;
        if (frame_done !== (frame_active && cycle == done_cyc)) begin
            failures++;
            $display("FAIL frame_done cyc=%0d got=%b exp=%b", cycle, frame_done, frame_active && cycle == done_cyc);
        end
        checks++;
        if (busy !== (frame_active && cycle < done_cyc)) begin
            failures++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cycle, busy, frame_active && cycle < done_cyc);
        end
        checks++;
        if (frames_dropped !== 8'(dropped_m) || err_underflow !== uf_m || err_range !== rg_m) begin
            failures++;
            $display("FAIL status cyc=%0d got=(%0d,%b,%b) exp=(%0d,%b,%b)", cycle,
                     frames_dropped, err_underflow, err_range, dropped_m, uf_m, rg_m);
        end
        if (wr_en === 1'b1) begin
            wr_cnt++; last_wr_addr = wr_addr; last_wr_cyc = cycle;
        end
        if (frame_done === 1'b1) begin
            done_seen++; done_seen_cyc = cycle;
        end

        // Drive inputs for the next edge.
        frame_start = fs_next;
        fs_next = 0;
        rst_in = rst_next;
        if (inj_valid) begin
            pixel_valid = 1; pixel_hcount = 11'(inj_h); pixel_vcount = 10'(inj_v);
            inj_valid = 0;
        end else if (q_due.size() > 0 && q_due[0] <= cycle) begin
            pixel_valid = 1;
            pixel_hcount = 11'(q_h.pop_front());
            pixel_vcount = 10'(q_v.pop_front());
            void'(q_due.pop_front());
        end else begin
            pixel_valid = 0;
        end
        hcount_axis_tready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
    endtask

    task automatic clear_obs();
        wr_cnt = 0; last_wr_addr = -1; last_wr_cyc = -1;
        done_seen = 0; done_seen_cyc = -1;
        first_h = -1; first_v = -1; last_h = -1; last_v = -1;
        prev_hs_h = -1; wraps = 0; sel11_cnt = 0; max_outst = 0; stall_cnt = 0;
    endtask

    // Start a frame and run until it returns to idle, bounded.
    task automatic run_frame();
        int n;
        fs_next = 1;
        step();
        step();
        n = 0;
        while (frame_active && n < 4000) begin
            step();
            n++;
        end
        checks++;
        if (frame_active) begin
            failures++;
            $display("FAIL frame_timeout got=active_after_%0d_cycles exp=idle", n);
        end
    endtask

    task automatic test_reset();
        int tv_high;
        rst_next = 1;
        repeat (4) step();
        checks++;
        if (hcount_axis_tvalid !== 1'b0 || hcount_axis_tdata !== 11'd0 || vcount_axis_tdata !== 10'd0 ||
            select_objs !== 2'b00) begin
            failures++;
            $display("FAIL reset_issue got=(%b,%0d,%0d,%b) exp=all_zero", hcount_axis_tvalid,
                     hcount_axis_tdata, vcount_axis_tdata, select_objs);
        end
        checks++;
        if (wr_en !== 1'b0 || wr_addr !== '0 || busy !== 1'b0 || frame_done !== 1'b0 ||
            frames_dropped !== 8'd0 || err_underflow !== 1'b0 || err_range !== 1'b0) begin
            failures++;
            $display("FAIL reset_status got=(%b,%0d,%b,%b,%0d,%b,%b) exp=all_zero", wr_en, wr_addr,
                     busy, frame_done, frames_dropped, err_underflow, err_range);
        end
        rst_next = 0;
        step();
        tv_high = 0;
        repeat (100) begin
            step();
            if (hcount_axis_tvalid !== 1'b0) tv_high++;
        end
        checks++;
        if (tv_high != 0) begin
            failures++;
            $display("FAIL idle_tvalid got=%0d_high_cycles exp=0", tv_high);
        end
    endtask

    task automatic test_full_frame();
        clear_obs();
        lat = 3; pct = 100;
        run_frame();
        checks++;
        if (issued != TOTAL || first_h != SX || first_v != SY || last_h != EX - 1 || last_v != EY - 1) begin
            failures++;
            $display("FAIL full_issue got=n%0d (%0d,%0d)..(%0d,%0d) exp=n%0d (%0d,%0d)..(%0d,%0d)",
                     issued, first_h, first_v, last_h, last_v, TOTAL, SX, SY, EX - 1, EY - 1);
        end
        checks++;
        if (wr_cnt != TOTAL || last_wr_addr != TOTAL - 1) begin
            failures++;
            $display("FAIL full_writes got=n%0d last=%0d exp=n%0d last=%0d", wr_cnt, last_wr_addr, TOTAL, TOTAL - 1);
        end
        checks++;
        if (done_seen != 1 || done_seen_cyc != last_wr_cyc + 1) begin
            failures++;
            $display("FAIL full_done got=n%0d at%0d exp=n1 at%0d", done_seen, done_seen_cyc, last_wr_cyc + 1);
        end
    endtask

    task automatic test_credits();
        clear_obs();
        lat = 20; pct = 100;
        run_frame();
        checks++;
        if (max_outst != MAXI || stall_cnt == 0) begin
            failures++;
            $display("FAIL credits got=max%0d stalls%0d exp=max%0d stalls>0", max_outst, stall_cnt, MAXI);
        end
        checks++;
        if (wr_cnt != TOTAL || done_seen != 1) begin
            failures++;
            $display("FAIL credits_writes got=n%0d done%0d exp=n%0d done1", wr_cnt, done_seen, TOTAL);
        end
    endtask

    task automatic test_backpressure();
        clear_obs();
        lat = 5; pct = 50;
        run_frame();
        pct = 100;
        checks++;
        if (wraps != H - 1) begin
            failures++;
            $display("FAIL row_wraps got=%0d exp=%0d", wraps, H - 1);
        end
        checks++;
        if (sel11_cnt != (DIV - SY) * W || wr_cnt != TOTAL) begin
            failures++;
            $display("FAIL region_sel got=sel11_%0d writes%0d exp=sel11_%0d writes%0d",
                     sel11_cnt, wr_cnt, (DIV - SY) * W, TOTAL);
        end
    endtask

    task automatic test_dropped();
        int n;
        clear_obs();
        lat = 3; pct = 100;
        fs_next = 1;
        step();
        repeat (10) step();
        repeat (3) begin
            fs_next = 1;
            step();
            repeat (4) step();
        end
        n = 0;
        while (frame_active && n < 4000) begin
            step();
            n++;
        end
        checks++;
        if (frames_dropped !== 8'd3 || done_seen != 1) begin
            failures++;
            $display("FAIL dropped got=%0d done%0d exp=3 done1", frames_dropped, done_seen);
        end
    endtask

    task automatic test_errors();
        int w0;
        inj_valid = 1; inj_h = SX + 5; inj_v = SY + 5;
        step();
        step();
        checks++;
        if (err_underflow !== 1'b1 || err_range !== 1'b0 || hcount_axis_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL underflow got=(uf%b rg%b tv%b) exp=(uf1 rg0 tv0)", err_underflow, err_range, hcount_axis_tvalid);
        end
        w0 = wr_cnt;
        inj_valid = 1; inj_h = 100; inj_v = 100;
        step();
        step();
        step();
        checks++;
        if (err_range !== 1'b1 || wr_cnt != w0) begin
            failures++;
            $display("FAIL range got=(rg%b writes+%0d) exp=(rg1 writes+0)", err_range, wr_cnt - w0);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        rst_next = 1;
        repeat (3) step();
        rst_next = 0;
        step();
        clear_obs();
        lat = 5; pct = 100;
        fs_next = 1;
        step();
        n = 0;
        while (issued < 50 && n < 500) begin
            step();
            n++;
        end
        rst_next = 1;
        step();
        rst_next = 0;
        step();
        repeat (30) step();
        checks++;
        if (done_seen != 0 || busy !== 1'b0 || err_underflow !== 1'b0 || err_range !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got=(done%0d busy%b uf%b rg%b) exp=(done0 busy0 uf0 rg0)",
                     done_seen, busy, err_underflow, err_range);
        end
        clear_obs();
        run_frame();
        checks++;
        if (first_h != SX || first_v != SY || wr_cnt != TOTAL || done_seen != 1 || err_underflow !== 1'b0) begin
            failures++;
            $display("FAIL restart got=(%0d,%0d) writes%0d done%0d uf%b exp=(%0d,%0d) writes%0d done1 uf0",
                     first_h, first_v, wr_cnt, done_seen, err_underflow, SX, SY, TOTAL);
        end
    endtask

    initial begin
        repeat (2) @(posedge aclk);
        #1;
        test_reset();
        test_full_frame();
        test_credits();
        test_backpressure();
        test_dropped();
        test_errors();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
